dmem_arbiter: RTL and testbench

//  Shares the single data memory port between two requesters: port 0 (CPU load/store unit) and

---
 rtl/dmem_pkg.sv | 40 ++++
 rtl/dmem_req_check.sv | 31 +++
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter and its legality checker.
// Mode encoding matches data_mem AddrMode; NOP parks the memory when no legal access runs.
package dmem_pkg;

  localparam int DMEM_DW = 32;
  localparam int DMEM_AW = 32;

  typedef enum logic [3:0] {
    AM_LB  = 4'd0,
    AM_LH  = 4'd1,
    AM_LW  = 4'd2,
    AM_LBU = 4'd3,
    AM_LHU = 4'd4,
    AM_SB  = 4'd5,
    AM_SH  = 4'd6,
    AM_SW  = 4'd7,
    AM_NOP = 4'b1000
  } addr_mode_t;

  localparam logic [3:0] MODE_NOP = AM_NOP;

  typedef struct packed {
    logic [3:0]         mode;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } dmem_req_t;

  function automatic logic [2:0] access_bytes(input logic [3:0] mode);
    case (mode)
      AM_LH, AM_LHU, AM_SH: access_bytes = 3'd2;
      AM_LW, AM_SW:         access_bytes = 3'd4;
      default:              access_bytes = 3'd1;
    endcase
  endfunction

  function automatic logic is_load(input logic [3:0] mode);
    return mode <= AM_LHU;
  endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Combinational legality check of one request: mode, natural alignment and implemented range.
// Zero latency; no handshake of its own.
module dmem_req_check
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int ADDR_REAL_WIDTH = 20
) (
  input  logic [3:0]            mode_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  err_o
);

  logic [2:0]          size;
  logic [ADDR_WIDTH:0] last_byte;
  logic                bad_mode;
  logic                bad_align;
  logic                bad_range;

  // One extra bit on last_byte so an access wrapping past the top of the address space is caught.
  always_comb begin
    size      = access_bytes(mode_i);
    last_byte = {1'b0, addr_i} + {{(ADDR_WIDTH-2){1'b0}}, size} - (ADDR_WIDTH+1)'(1);
    bad_mode  = mode_i[3];
    bad_align = ((size == 3'd2) && addr_i[0]) ||
                ((size == 3'd4) && (addr_i[1:0] != 2'b00));
    bad_range = |last_byte[ADDR_WIDTH:ADDR_REAL_WIDTH];
    err_o     = bad_mode | bad_align | bad_range;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin share of the data memory port between the LSU (port 0) and the loader (port 1).
// Handshake at edge N, memory access in cycle N+1, response in N+2; loser is stalled with ready low.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH      = DMEM_DW,
  parameter int ADDR_WIDTH      = DMEM_AW,
  parameter int ADDR_REAL_WIDTH = 20,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  p0_valid_i,
  output logic                  p0_ready_o,
  input  logic [3:0]            p0_mode_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_rvalid_o,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,
  output logic                  p0_err_o,

  input  logic                  p1_valid_i,
  output logic                  p1_ready_o,
  input  logic [3:0]            p1_mode_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_rvalid_o,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,
  output logic                  p1_err_o,

  output logic [3:0]            mem_mode_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,

  output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]            state_q, state_d;
  logic                  last_owner_q, last_owner_d;
  logic                  owner_q, owner_d;
  dmem_req_t             req_q, req_d;
  logic                  err_q, err_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [1:0]            rerr_q, rerr_d;
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic [DATA_WIDTH-1:0] rdata_d [2];
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic      both_vld;
  logic [1:0] gnt;
  logic      win;
  logic      hs;
  dmem_req_t sel_req;
  logic      sel_err;
  logic      access;

  // The stage retires every cycle, so a grant is offered whenever anyone is valid.
  always_comb begin
    both_vld = p0_valid_i & p1_valid_i;
    if (both_vld) begin
      gnt = last_owner_q ? 2'b01 : 2'b10;
    end else begin
      gnt = {p1_valid_i, p0_valid_i};
    end
    win = gnt[1];
    hs  = |gnt;
  end

  always_comb begin
    sel_req.mode  = win ? p1_mode_i  : p0_mode_i;
    sel_req.addr  = win ? p1_addr_i  : p0_addr_i;
    sel_req.wdata = win ? p1_wdata_i : p0_wdata_i;
  end

  dmem_req_check #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .ADDR_REAL_WIDTH (ADDR_REAL_WIDTH)
  ) u_check (
    .mode_i (sel_req.mode),
    .addr_i (sel_req.addr),
    .err_o  (sel_err)
  );

  always_comb begin
    state_d      = hs ? ST_ACCESS : ST_IDLE;
    last_owner_d = hs ? win : last_owner_q;
    owner_d      = hs ? win : owner_q;
    req_d        = hs ? sel_req : req_q;
    err_d        = hs ? sel_err : err_q;
    rvalid_d     = 2'b00;
    rerr_d       = 2'b00;
    rdata_d      = rdata_q;
    // Stores and rejected requests respond with zero data; loads latch the memory read.
    if (state_q == ST_ACCESS) begin
      rvalid_d[owner_q] = 1'b1;
      rerr_d[owner_q]   = err_q;
      rdata_d[owner_q]  = (!err_q && is_load(req_q.mode)) ? mem_rdata_i : '0;
    end
    cnt_d = (both_vld && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      req_q        <= '0;
      err_q        <= 1'b0;
      rvalid_q     <= 2'b00;
      rerr_q       <= 2'b00;
      rdata_q[0]   <= '0;
      rdata_q[1]   <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      req_q        <= req_d;
      err_q        <= err_d;
      rvalid_q     <= rvalid_d;
      rerr_q       <= rerr_d;
      rdata_q[0]   <= rdata_d[0];
      rdata_q[1]   <= rdata_d[1];
      cnt_q        <= cnt_d;
    end
  end

  // Memory sees the stage only for a legal access; reset drops it to NOP immediately.
  assign access      = (state_q == ST_ACCESS) && !err_q;
  assign mem_mode_o  = access ? req_q.mode  : MODE_NOP;
  assign mem_addr_o  = access ? req_q.addr  : '0;
  assign mem_wdata_o = access ? req_q.wdata : '0;

  assign p0_ready_o     = gnt[0];
  assign p1_ready_o     = gnt[1];
  assign p0_rvalid_o    = rvalid_q[0];
  assign p1_rvalid_o    = rvalid_q[1];
  assign p0_err_o       = rerr_q[0];
  assign p1_err_o       = rerr_q[1];
  assign p0_rdata_o     = rdata_q[0];
  assign p1_rdata_o     = rdata_q[1];
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-array data_mem and a transaction-level reference.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        p0_valid = 0, p1_valid = 0;
  logic        p0_ready, p1_ready;
  logic [3:0]  p0_mode = 0, p1_mode = 0;
  logic [31:0] p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0;
  logic        p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [3:0]  mem_mode;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] conflict_cnt;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid_i(p0_valid), .p0_ready_o(p0_ready), .p0_mode_i(p0_mode), .p0_addr_i(p0_addr),
    .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata), .p0_err_o(p0_err),
    .p1_valid_i(p1_valid), .p1_ready_o(p1_ready), .p1_mode_i(p1_mode), .p1_addr_i(p1_addr),
    .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata), .p1_err_o(p1_err),
    .mem_mode_o(mem_mode), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .conflict_cnt_o(conflict_cnt)
  );

  typedef struct {
    logic [3:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t q0[$];
  req_t q1[$];
  int   grant_log[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [7:0] dm [0:65535];
  logic [7:0] rm [0:65535];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt_load(input logic [3:0] m, input logic [31:0] w);
    case (m)
      AM_LB:   return {{24{w[7]}}, w[7:0]};
      AM_LH:   return {{16{w[15]}}, w[15:0]};
      AM_LW:   return w;
      AM_LBU:  return {24'h0, w[7:0]};
      AM_LHU:  return {16'h0, w[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int store_bytes(input logic [3:0] m);
    if (m == AM_SB) return 1;
    if (m == AM_SH) return 2;
    if (m == AM_SW) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] dm_word(input logic [31:0] a);
    logic [15:0] i;
    i = a[15:0];
    return {dm[i + 16'd3], dm[i + 16'd2], dm[i + 16'd1], dm[i]};
  endfunction

  function automatic logic [31:0] rm_word(input logic [31:0] a);
    logic [15:0] i;
    i = a[15:0];
    return {rm[i + 16'd3], rm[i + 16'd2], rm[i + 16'd1], rm[i]};
  endfunction

  // data_mem stand-in: combinational read, write at the edge closing a store cycle.
  assign mem_rdata = fmt_load(mem_mode, dm_word(mem_addr));

  initial forever begin : env_write
    logic [3:0]  wm;
    logic [31:0] wa, wd;
    logic [15:0] idx;
    @(negedge clk);
    wm = mem_mode; wa = mem_addr; wd = mem_wdata;
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < store_bytes(wm); k++) begin
        idx = wa[15:0] + 16'(k);
        dm[idx] = wd[8*k +: 8];
      end
    end
  end

  // Reference: legality from the size/alignment/range rules, data from its own byte memory.
  function automatic bit m_illegal(input logic [3:0] m, input logic [31:0] a);
    longint unsigned sz, la;
    if (m > 4'd7) return 1'b1;
    sz = (m == AM_LB || m == AM_LBU || m == AM_SB) ? 1 : (m == AM_LW || m == AM_SW) ? 4 : 2;
    la = {32'h0, a};
    if (la % sz != 0) return 1'b1;
    return (la + sz - 1) >= (64'd1 << 20);
  endfunction

  typedef struct {
    bit          v;
    bit          port;
    bit          err;
    logic [3:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        m_cap = '{default: 0};
  txn_t        m_pend = '{default: 0};
  bit          m_both = 0;
  bit          m_last = 1;
  bit          m_rv = 0, m_rport = 0, m_rerr = 0;
  logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
  int unsigned m_cnt = 0;

  initial forever begin : model_step
    logic [31:0] d;
    logic [15:0] idx;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cap.v = 0; m_pend.v = 0; m_both = 0; m_last = 1;
      m_rv = 0; m_rdata[0] = 0; m_rdata[1] = 0; m_cnt = 0;
    end else begin
      m_rv = m_pend.v;
      if (m_pend.v) begin
        m_rport = m_pend.port;
        m_rerr  = m_pend.err;
        d = 32'h0;
        if (!m_pend.err) begin
          if (store_bytes(m_pend.mode) != 0) begin
            for (int k = 0; k < store_bytes(m_pend.mode); k++) begin
              idx = m_pend.addr[15:0] + 16'(k);
              rm[idx] = m_pend.wdata[8*k +: 8];
            end
          end else begin
            d = fmt_load(m_pend.mode, rm_word(m_pend.addr));
          end
        end
        m_rdata[m_pend.port] = d;
      end
      m_pend = m_cap;
      if (m_cap.v) m_last = m_cap.port;
      if (m_both && m_cnt != 32'hFFFF) m_cnt++;
      m_cap.v = 0;
      m_both = 0;
    end
  end

  initial forever begin : compare
    bit w0, w1;
    bit acc;
    @(negedge clk);
    w0 = p0_valid && (!p1_valid || m_last);
    w1 = p1_valid && !w0;
    acc = m_pend.v && !m_pend.err;
    chk("p0_ready", p0_ready, w0);
    chk("p1_ready", p1_ready, w1);
    chk("mem_mode", mem_mode, acc ? m_pend.mode : 4'h8);
    chk("mem_addr", mem_addr, acc ? m_pend.addr : 32'h0);
    chk("mem_wdata", mem_wdata, acc ? m_pend.wdata : 32'h0);
    chk("p0_rvalid", p0_rvalid, m_rv && !m_rport);
    chk("p1_rvalid", p1_rvalid, m_rv && m_rport);
    chk("p0_err", p0_err, m_rv && !m_rport && m_rerr);
    chk("p1_err", p1_err, m_rv && m_rport && m_rerr);
    chk("p0_rdata", p0_rdata, m_rdata[0]);
    chk("p1_rdata", p1_rdata, m_rdata[1]);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    m_both = rst_n && p0_valid && p1_valid;
    m_cap.v = rst_n && (w0 || w1);
    m_cap.port = w1;
    m_cap.mode = w1 ? p1_mode : p0_mode;
    m_cap.addr = w1 ? p1_addr : p0_addr;
    m_cap.wdata = w1 ? p1_wdata : p0_wdata;
    m_cap.err = m_illegal(m_cap.mode, m_cap.addr);
    if (p0_valid && p0_ready) grant_log.push_back(0);
    if (p1_valid && p1_ready) grant_log.push_back(1);
  end

  // One cycle: present queue heads after the edge, retire accepted heads at the negedge.
  task automatic tick();
    @(posedge clk); #1;
    p0_valid = (q0.size() != 0);
    p0_mode  = p0_valid ? q0[0].mode  : 4'h0;
    p0_addr  = p0_valid ? q0[0].addr  : 32'h0;
    p0_wdata = p0_valid ? q0[0].wdata : 32'h0;
    p1_valid = (q1.size() != 0);
    p1_mode  = p1_valid ? q1[0].mode  : 4'h0;
    p1_addr  = p1_valid ? q1[0].addr  : 32'h0;
    p1_wdata = p1_valid ? q1[0].wdata : 32'h0;
    @(negedge clk);
    if (p0_valid && p0_ready) void'(q0.pop_front());
    if (p1_valid && p1_ready) void'(q1.pop_front());
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) tick();
    chk(name, q0.size() + q1.size(), 0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0; p0_valid = 0; p1_valid = 0;
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dm[i] = 8'(i) ^ 8'hA5;
      rm[i] = 8'(i) ^ 8'hA5;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);

    repeat (10) tick();
    chk("idle_mode", mem_mode, 32'h8);
    chk("idle_addr", mem_addr, 32'h0);
    chk("idle_rvalid", {p1_rvalid, p0_rvalid}, 32'h0);
    chk("idle_cnt", conflict_cnt, 32'h0);

    // Store then load of the same word, back to back on port 0.
    q0.push_back('{AM_SW, 32'h1000, 32'hDEADBEEF});
    q0.push_back('{AM_LW, 32'h1000, 32'h0});
    tick();
    tick();
    chk("sw_mem_mode", mem_mode, 32'h7);
    chk("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("sw_ack_n2", p0_rvalid, 32'h1);
    chk("lw_mem_mode", mem_mode, 32'h2);
    tick();
    chk("lw_resp_n3", p0_rvalid, 32'h1);
    chk("lw_rdata", p0_rdata, 32'hDEADBEEF);
    drain("t2_drain");

    // Sustained contention straight out of reset.
    do_reset();
    grant_log.delete();
    repeat (3) q0.push_back('{AM_LW, 32'h0, 32'h0});
    repeat (2) q1.push_back('{AM_LW, 32'h4, 32'h0});
    repeat (5) tick();
    drain("t3_drain");
    chk("rr_count", grant_log.size(), 32'd5);
    if (grant_log.size() == 5) begin
      chk("rr_g0", grant_log[0], 32'd0);
      chk("rr_g1", grant_log[1], 32'd1);
      chk("rr_g2", grant_log[2], 32'd0);
      chk("rr_g3", grant_log[3], 32'd1);
      chk("rr_g4", grant_log[4], 32'd0);
    end
    chk("rr_cnt", conflict_cnt, 32'd4);
    chk("rr_p0_data", p0_rdata, 32'hA6A7A4A5);
    chk("rr_p1_data", p1_rdata, 32'hA2A3A0A1);

    // Misaligned and out-of-range requests, then the highest legal word.
    q1.push_back('{AM_LH, 32'h1001, 32'h0});
    q1.push_back('{AM_LW, 32'h100000, 32'h0});
    q1.push_back('{AM_LW, 32'hFFFFC, 32'h0});
    tick();
    tick();
    chk("err1_nop", mem_mode, 32'h8);
    tick();
    chk("err1_rv", {p1_rvalid, p1_err}, 32'h3);
    chk("err1_rdata", p1_rdata, 32'h0);
    chk("err2_nop", mem_mode, 32'h8);
    tick();
    chk("err2_rv", {p1_rvalid, p1_err}, 32'h3);
    chk("top_mem_addr", mem_addr, 32'hFFFFC);
    tick();
    chk("top_rv", {p1_rvalid, p1_err}, 32'h2);
    chk("top_rdata", p1_rdata, 32'h5A5B5859);
    drain("t4_drain");

    // Byte store, then signed and unsigned byte loads and the surrounding word.
    q0.push_back('{AM_SB, 32'h2003, 32'h12345680});
    q0.push_back('{AM_LB, 32'h2003, 32'h0});
    q0.push_back('{AM_LBU, 32'h2003, 32'h0});
    q0.push_back('{AM_LW, 32'h2000, 32'h0});
    repeat (4) tick();
    chk("lb_sext", p0_rdata, 32'hFFFFFF80);
    tick();
    chk("lbu_zext", p0_rdata, 32'h00000080);
    tick();
    chk("sb_word", p0_rdata, 32'h80A7A4A5);
    drain("t5_drain");

    // Reset lands in the access cycle of a store.
    q0.push_back('{AM_SW, 32'h3000, 32'h12345678});
    tick();
    @(posedge clk); #1;
    p0_valid = 0;
    chk("rst_acc_mode", mem_mode, 32'h7);
    #2 rst_n = 0;
    #1;
    chk("rst_async_nop", mem_mode, 32'h8);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_no_rv", p0_rvalid, 32'h0);
    chk("rst_no_commit", dm_word(32'h3000), 32'hA6A7A4A5);
    grant_log.delete();
    q0.push_back('{AM_LW, 32'h3000, 32'h0});
    q1.push_back('{AM_LW, 32'h0, 32'h0});
    repeat (4) tick();
    chk("post_rst_first", grant_log.size() > 0 ? grant_log[0] : -1, 32'd0);
    chk("post_rst_p0", p0_rdata, 32'hA6A7A4A5);
    chk("post_rst_p1", p1_rdata, 32'hA6A7A4A5);
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
